// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - shared register map, status layout and FSM encoding
package mmio_uart_tx_pkg;

    // Register offsets within the 16-byte window (addr[3:0]).
    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;

    // STATUS register bit positions.
    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - CPU data-memory bus slice seen by the UART transmitter
// Signals:
//   rd_en, wr_en  read / write strobes from the CPU data port
//   addr, wdata   CPU address and write data
//   hit           this block owns addr (combinational, from the slave)
//   rdata         register read data (combinational, from the slave)
interface mmio_uart_tx_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rdata;

    modport master (
        output rd_en, wr_en, addr, wdata,
        input  hit, rdata
    );

    modport slave (
        input  rd_en, wr_en, addr, wdata,
        output hit, rdata
    );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// rtl/mmio_uart_tx_sync_fifo.sv - single-clock FIFO feeding the UART serializer
// Ports:
//   clk, reset          clock, async active-low reset
//   push, push_data     enqueue request and data
//   pop, pop_data       dequeue request; pop_data shows the head combinationally
//   full, empty, count  occupancy flags and entry count
module mmio_uart_tx_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    // A pop in the same cycle frees the slot, so a push to a full FIFO is still taken.
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
// Ports:
//   clk       system clock
//   reset     async active-low reset
//   bus       CPU data bus slave (rd_en/wr_en/addr/wdata in, hit/rdata out)
//   uart_txd  registered serial output, idles high
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter logic [15:0] CLK_DIV    = 16'd868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    mmio_uart_tx_if.slave   bus,
    output logic            uart_txd
);
    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = CLK_DIV - 16'd1;

    logic [3:0]    offset;
    logic          wr_txdata;
    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        baud_done;

    logic unused_wdata;
    assign unused_wdata = &{1'b0, bus.wdata[31:8]};

    assign offset    = bus.addr[3:0];
    assign bus.hit   = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign wr_txdata = bus.wr_en && bus.hit && (offset == OFF_TXDATA);

    mmio_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txdata),
        .push_data (bus.wdata[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        status                                  = '0;
        status[STAT_BUSY]                       = (state_q != ST_IDLE);
        status[STAT_FULL]                       = fifo_full;
        status[STAT_EMPTY]                      = fifo_empty;
        status[STAT_COUNT_LSB +: STAT_COUNT_W]  = STAT_COUNT_W'(fifo_count);
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd_en && bus.hit && (offset == OFF_STATUS)) bus.rdata = status;
    end

    // State register; txd is registered so the line never glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign baud_done = (baud_q == '0);

    // Next-state: every state change reloads the baud counter.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_done ? baud_q : baud_q - 16'd1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = baud_q;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = BAUD_RELOAD;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = BAUD_RELOAD;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output: line level for the state being entered, latched at the same edge.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    assign uart_txd = txd_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int          DIV  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic uart_txd;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (16'(DIV)),
        .FIFO_DEPTH (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int abort_cnt = 0;
    logic [7:0] exp_q[$];

    always @(negedge reset) abort_cnt++;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic write_tx(input logic [7:0] b, input bit expect_tx);
        bus.addr  = BASE;
        bus.wdata = {24'h5A5A5A, b};
        bus.wr_en = 1'b1;
        if (expect_tx) exp_q.push_back(b);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic read_status(output logic [31:0] v);
        bus.addr  = BASE + 32'h4;
        bus.rd_en = 1'b1;
        #1;
        v = bus.rdata;
        bus.rd_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        logic [31:0] s;
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            read_status(s);
            if (s == 32'h4) done = 1'b1;
            else @(negedge clk);
        end
        check(name, 64'(done), 64'd1);
    endtask

    // Receiver: sample mid-bit (DIV=4, start detected at offset 0 -> samples at 2, 6, ..., 38).
    initial begin : rx_mon
        int         a;
        logic [7:0] d;
        logic       sb, eb;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && uart_txd === 1'b0) begin
                a = abort_cnt;
                repeat (2) @(negedge clk);
                sb = uart_txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    d[i] = uart_txd;
                end
                repeat (4) @(negedge clk);
                eb = uart_txd;
                @(negedge clk);
                if (a == abort_cnt) begin
                    check("rx_start_bit", 64'(sb), 64'd0);
                    check("rx_stop_bit", 64'(eb), 64'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected_frame: got=0x%02h expected=no frame", d);
                    end else begin
                        check("rx_byte", 64'(d), 64'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] s;
        logic [40:0] got_v, exp_v;
        logic [7:0]  byte_v;
        bit          all_high;

        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;

        vecs[0] = '{32'hFFFF_0004, 1'b1, 1'b0, 1'b1, 32'h0000_0004};
        vecs[1] = '{32'hFFFF_0004, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
        vecs[2] = '{32'hFFFF_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_0008, 1'b1, 1'b1, 1'b1, 32'h0000_0000};
        vecs[4] = '{32'hFFFF_000C, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
        vecs[5] = '{32'hFFFE_0004, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[6] = '{32'hFFFF_0014, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[7] = '{32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[8] = '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000};
        vecs[9] = '{32'hFFFF_0004, 1'b1, 1'b1, 1'b1, 32'h0000_0004};

        // Reset then idle
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_txd", 64'(uart_txd), 64'd1);
        read_status(s);
        check("reset_status", 64'(s), 64'h4);
        bus.addr = 32'h0000_0010;
        #1;
        check("reset_hit_outside", 64'(bus.hit), 64'd0);

        // Register decode table (FIFO empty, idle)
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.addr  = vecs[i].addr;
            bus.rd_en = vecs[i].rd;
            bus.wr_en = vecs[i].wr;
            bus.wdata = 32'hDEAD_BEEF;
            #1;
            check($sformatf("vec%0d_hit", i), 64'(bus.hit), 64'(vecs[i].exp_hit));
            check($sformatf("vec%0d_rdata", i), 64'(bus.rdata), 64'(vecs[i].exp_rdata));
        end
        @(negedge clk);
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        repeat (3) @(negedge clk);
        read_status(s);
        check("decode_writes_ignored", 64'(s), 64'h4);
        check("decode_txd_idle", 64'(uart_txd), 64'd1);

        // Single byte: cycle-exact waveform
        byte_v = 8'h55;
        exp_v[0] = 1'b1;
        for (int i = 1; i <= 4; i++) exp_v[i] = 1'b0;
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < 4; k++) exp_v[5 + 4*b + k] = byte_v[b];
        for (int i = 37; i <= 40; i++) exp_v[i] = 1'b1;
        @(negedge clk);
        write_tx(8'h55, 1'b1);
        got_v[0] = uart_txd;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            got_v[i] = uart_txd;
        end
        check("single_waveform", 64'(got_v), 64'(exp_v));
        read_status(s);
        check("single_busy_n40", 64'(s[0]), 64'd1);
        @(negedge clk);
        read_status(s);
        check("single_idle_n41", 64'(s), 64'h4);

        // Back-to-back frames
        @(negedge clk);
        write_tx(8'hA5, 1'b1);
        write_tx(8'h3C, 1'b1);
        repeat (8) @(negedge clk);
        read_status(s);
        check("b2b_status_count1", 64'(s), 64'h101);
        repeat (31) @(negedge clk);
        check("b2b_stop_n40", 64'(uart_txd), 64'd1);
        @(negedge clk);
        check("b2b_start_n41", 64'(uart_txd), 64'd0);
        read_status(s);
        check("b2b_status_n41", 64'(s), 64'h5);
        wait_idle("b2b_idle", 200);

        // Overflow: 9th byte dropped
        @(negedge clk);
        write_tx(8'h11, 1'b1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) write_tx(8'h20 + 8'(i), i < 8);
        read_status(s);
        check("ovf_status", 64'(s), 64'h803);
        wait_idle("ovf_idle", 600);
        check("ovf_drained", 64'(exp_q.size()), 64'd0);

        // Push coinciding with STOP-expiry pop on a full FIFO
        @(negedge clk);
        write_tx(8'h40, 1'b1);
        for (int i = 0; i < 8; i++) write_tx(8'h41 + 8'(i), 1'b1);
        read_status(s);
        check("pp_full_before", 64'(s), 64'h803);
        repeat (32) @(negedge clk);
        write_tx(8'h99, 1'b1);
        #1;
        read_status(s);
        check("pp_count_stays8", 64'(s), 64'h803);
        check("pp_next_start", 64'(uart_txd), 64'd0);
        wait_idle("pp_idle", 600);
        check("pp_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-frame during DATA bit 3
        @(negedge clk);
        write_tx(8'hF0, 1'b0);
        write_tx(8'h0F, 1'b0);
        repeat (17) @(negedge clk);
        check("rst_bit3_low", 64'(uart_txd), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_txd_async_high", 64'(uart_txd), 64'd1);
        read_status(s);
        check("rst_status_in_reset", 64'(s), 64'h4);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        all_high = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) all_high = 1'b0;
        end
        check("rst_no_further_frames", 64'(all_high), 64'd1);
        read_status(s);
        check("rst_status_after", 64'(s), 64'h4);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-memory bus, alongside dram and downstream of the riscv data port.
- Decodes a small register window; the CPU writes bytes into an 8-deep TX FIFO; a serializer shifts them out as 8N1 frames.
- Board logic uses `hit` to select this block's `rdata` over the dram read data.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, base of the 16-byte register window; bits [3:0] must be 0.
- CLK_DIV, 16'd868, clocks per UART bit; legal range 2..65535.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_en  in  1  CPU data read strobe (dram_read).
- wr_en  in  1  CPU data write strobe (dram_write).
- addr  in  32  CPU data address.
- wdata  in  32  CPU write data.
- hit  out  1  addr[31:4]==BASE_ADDR[31:4]; combinational.
- rdata  out  32  register read data; combinational, same cycle as rd_en.
- uart_txd  out  1  serial output; idles high.

Behaviour:
- Register map, offset = addr[3:0]:
  - 0x0 TXDATA: write pushes wdata[7:0]; read returns 0.
  - 0x4 STATUS, read-only: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bits[12:8] count, others 0.
  - Other offsets: read 0, writes ignored.
- rdata = 0 when !hit or !rd_en. Write action requires wr_en & hit. If rd_en and wr_en are both high, the write is performed.
- Reset (async, reset==0):
  - FIFO count = 0, pointers = 0, FSM = IDLE, uart_txd = 1, shift register and counters = 0.
  - Reset mid-frame aborts the frame immediately; uart_txd goes high asynchronously.
- FIFO push:
  - Accepted if count<FIFO_DEPTH, or a pop occurs in the same cycle. A push to a full FIFO with no pop is silently dropped.
  - Count updates at the write edge.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- FSM, states IDLE, START, DATA, STOP:
  - IDLE: uart_txd=1. If FIFO non-empty: pop the head into an 8-bit shift register, load baud counter = CLK_DIV-1, go to START. A byte written at edge N reaches IDLE-empty=0 after edge N, so START begins at edge N+1.
  - START: uart_txd=0 for CLK_DIV cycles. When baud counter = 0: reload, bit index = 0, go to DATA.
  - DATA: uart_txd = shift[0], LSB first. Each baud expiry shifts right and increments the index. After index 7 expires, go to STOP.
  - STOP: uart_txd=1 for CLK_DIV cycles. At expiry: if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Frame length is exactly 10*CLK_DIV cycles; back-to-back frames are contiguous.
- uart_txd is a registered output (no glitches); only reset forces it asynchronously.
- Baud counter counts down and reloads CLK_DIV-1 on every state transition.

Decomposition:
- Shared package holds:
  - register offsets OFF_TXDATA=4'h0, OFF_STATUS=4'h4;
  - STATUS bit positions;
  - FSM state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3).
- One sub-module: sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH) with push/pop/full/empty/count. Its reset has the same async active-low convention.

Test Plan:
- Reset then idle (CLK_DIV=4): hold reset low 3 cycles, release → uart_txd=1; a STATUS read returns 0x0000_0004 (empty); hit=0 for addr 0x0000_0010.
- Single byte: write 0x55 to BASE+0 at edge N → txd=0 over cycles N+1..N+4; then bits 1,0,1,0,1,0,1,0, 4 cycles each; stop high 4 cycles; busy clears at N+41.
- Back-to-back: write 0xA5, 0x3C on consecutive cycles → two frames of 40 cycles each with no idle gap; STATUS count reads 1 during the first frame.
- Overflow: with FSM mid-frame, write 9 bytes → count saturates at 8; STATUS=0x0000_0803 (busy, full); the 9th byte is never transmitted.
- Reset mid-frame: assert reset during DATA bit 3 → uart_txd=1 immediately; after release, count=0 and no further frames.
- Simultaneous push and pop at full: FIFO full, STOP expiry coincides with a TXDATA write → write accepted; count stays 8.
